banco_registradores_param: RTL and testbench

Parametrised multi-port register file, successor to the fixed 8x8 two-read-port bank in the datapath. It provides N_RD registered read ports, one write port, optional write-to-read bypass, per-register reset values, and a hardware clear sweep that restores all registers to their reset values without asserting rst. It sits between decode (register addresses) and the ALU (operands), and takes writeback on the write port.

---
 rtl/banco_registradores_param.sv | 138 +++++++++++++
 tb/tb_banco_registradores_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/banco_registradores_param.sv
// Parametrised register file: N_RD registered read ports, one write port,
// optional write-to-read bypass, per-register reset values (INIT_BASE + i)
// and a hardware clear sweep that restores every register without rst.
//
// Read handshake: rd_en is a request with no backpressure. When it is
// accepted (IDLE only), rd_data is loaded at the edge and rd_valid is high
// for the following cycle. When it is not accepted, rd_data holds and
// rd_valid is low.
module banco_registradores_param #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 3,
  parameter int                N_RD      = 2,
  parameter bit                BYPASS    = 1'b1,
  parameter logic [DATA_W-1:0] INIT_BASE = 8'hA0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic                     rd_valid,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     wr_drop,
  output logic                     dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic [DATA_W-1:0]       regs_q [DEPTH];
  logic [N_RD*DATA_W-1:0]  rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    wr_drop_q, wr_drop_d;

  logic                    wr_acc;
  logic                    we;
  logic [ADDR_W-1:0]       waddr;
  logic [DATA_W-1:0]       wdata;

  // State register: FSM state and sweep pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: start a sweep on clr_req in IDLE, leave after the last register.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) state_d = SWEEP;
      end
      SWEEP: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs of the FSM: write port mux, read capture with bypass, drop flag.
  always_comb begin
    wr_acc     = 1'b0;
    rd_valid_d = 1'b0;
    we         = 1'b0;
    waddr      = wr_addr;
    wdata      = wr_data;
    wr_drop_d  = 1'b0;
    rd_data_d  = rd_data_q;
    unique case (state_q)
      IDLE: begin
        wr_acc     = wr_en;
        we         = wr_en;
        rd_valid_d = rd_en;
      end
      SWEEP: begin
        we        = 1'b1;
        waddr     = ptr_q;
        wdata     = INIT_BASE + DATA_W'(ptr_q);
        wr_drop_d = wr_en;
      end
      default: ;
    endcase
    if (rd_valid_d) begin
      for (int k = 0; k < N_RD; k++) begin
        if (BYPASS && wr_acc && (rd_addr[k*ADDR_W +: ADDR_W] == wr_addr))
          rd_data_d[k*DATA_W +: DATA_W] = wr_data;
        else
          rd_data_d[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  // Register array: reset to INIT_BASE + i, written by the port or the sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= INIT_BASE + DATA_W'(i);
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Registered read data, read valid and write-drop pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_drop   = wr_drop_q;
  assign busy      = (state_q == SWEEP);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_banco_registradores_param.sv
// Bench for banco_registradores_param: two 8x8 instances sharing inputs
// (BYPASS=1 and BYPASS=0) tracked by a behavioural model, plus a 16x16
// three-port instance exercised with directed constants.
module tb_banco_registradores_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- narrow instances (shared inputs) ----------------
  logic        wr_en = 0, rd_en = 0, clr_req = 0;
  logic [2:0]  wr_addr = 0;
  logic [7:0]  wr_data = 0;
  logic [5:0]  rd_addr = 0;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b, wr_drop_a, wr_drop_b;
  logic        dbg_a, dbg_b;

  banco_registradores_param u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .clr_req(clr_req), .busy(busy_a), .wr_drop(wr_drop_a), .dbg_state(dbg_a)
  );

  banco_registradores_param #(.BYPASS(1'b0)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .clr_req(clr_req), .busy(busy_b), .wr_drop(wr_drop_b), .dbg_state(dbg_b)
  );

  // ---------------- wide instance ----------------
  logic        w_wr_en = 0, w_rd_en = 0, w_clr = 0;
  logic [3:0]  w_wr_addr = 0;
  logic [15:0] w_wr_data = 0;
  logic [11:0] w_rd_addr = 0;
  logic [47:0] w_rd_data;
  logic        w_rd_valid, w_busy, w_wr_drop, w_dbg;

  banco_registradores_param #(
    .DATA_W(16), .ADDR_W(4), .N_RD(3), .BYPASS(1'b1), .INIT_BASE(16'h1000)
  ) u_w (
    .clk(clk), .rst(rst), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .rd_en(w_rd_en), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_valid(w_rd_valid),
    .clr_req(w_clr), .busy(w_busy), .wr_drop(w_wr_drop), .dbg_state(w_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int drop_cnt = 0;

  logic [7:0]  m_mem [8];
  int          m_left;        // sweep cycles still to run, 0 = idle
  logic [15:0] m_rd_a, m_rd_b;
  logic        m_valid, m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'(8'hA0 + i);
    m_left  = 0;
    m_rd_a  = '0;
    m_rd_b  = '0;
    m_valid = 1'b0;
    m_drop  = 1'b0;
  endtask

  // One clock: advance the model from the current inputs, then compare.
  task automatic tick();
    int a;
    int idx;
    if (m_left > 0) begin
      idx = 8 - m_left;
      m_mem[idx] = 8'(8'hA0 + idx);
      m_left--;
      m_valid = 1'b0;
      m_drop  = wr_en;
    end else begin
      m_drop  = 1'b0;
      m_valid = rd_en;
      if (rd_en) begin
        for (int k = 0; k < 2; k++) begin
          a = int'(rd_addr[k*3 +: 3]);
          m_rd_b[k*8 +: 8] = m_mem[a];
          m_rd_a[k*8 +: 8] = (wr_en && a == int'(wr_addr)) ? wr_data : m_mem[a];
        end
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (clr_req) m_left = 8;
    end
    @(posedge clk);
    #1;
    chk("rd_data_a",  rd_data_a,  m_rd_a);
    chk("rd_data_b",  rd_data_b,  m_rd_b);
    chk("rd_valid_a", rd_valid_a, m_valid);
    chk("rd_valid_b", rd_valid_b, m_valid);
    chk("busy_a",     busy_a,     m_left > 0);
    chk("busy_b",     busy_b,     m_left > 0);
    chk("wr_drop_a",  wr_drop_a,  m_drop);
    chk("wr_drop_b",  wr_drop_b,  m_drop);
  endtask

  // Run a sweep already started; counts busy cycles (bounded).
  task automatic run_sweep(input bit hold_clr, input int wr_cyc, output int n);
    n = 0;
    while (busy_a && n < 40) begin
      n++;
      clr_req = hold_clr && (m_left > 1);
      if (n == wr_cyc) begin
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'hFF;
      end else begin
        wr_en = 1'b0;
      end
      rd_en   = 1'b1;
      rd_addr = 6'($urandom_range(0, 63));
      tick();
      if (wr_drop_a) drop_cnt++;
    end
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    model_reset();

    // Reset state
    #2;
    chk("reset_rd_data", rd_data_a, 16'h0);
    chk("reset_rd_valid", rd_valid_a, 1'b0);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_wr_drop", wr_drop_a, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Defaults
    rd_en = 1'b1; rd_addr = {3'd3, 3'd0};
    tick();
    chk("default_3_0", rd_data_a, 16'hA3A0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = {3'(i), 3'(i)};
      tick();
      chk("default_all", rd_data_a, {8'(8'hA0 + i), 8'(8'hA0 + i)});
    end

    // Same-cycle write/read: bypass vs. old data
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C; rd_addr = {3'd5, 3'd5};
    tick();
    chk("bypass1_same", rd_data_a, 16'h3C3C);
    chk("bypass0_same", rd_data_b, 16'hA5A5);
    wr_en = 1'b0;
    tick();
    chk("bypass0_next", rd_data_b, 16'h3C3C);

    // Clear sweep restores written registers
    rd_en = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11; tick();
    wr_addr = 3'd7; wr_data = 8'h22; tick();
    wr_en = 1'b0; clr_req = 1'b1; tick();
    clr_req = 1'b0;
    run_sweep(1'b0, 0, n);
    chk("sweep_len", n, 8);
    rd_en = 1'b1; rd_addr = {3'd7, 3'd2}; tick();
    chk("after_sweep_7_2", rd_data_a, 16'hA7A2);

    // Write during sweep is dropped; held clr_req does not restart
    drop_cnt = 0;
    rd_en = 1'b0; clr_req = 1'b1; tick();
    run_sweep(1'b1, 2, n);
    chk("sweep_len_held_clr", n, 8);
    chk("wr_drop_pulses", drop_cnt, 1);
    rd_en = 1'b1; rd_addr = {3'd4, 3'd4}; tick();
    chk("reg4_after_drop", rd_data_a, 16'hA4A4);

    // clr_req together with a write in IDLE
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h55; clr_req = 1'b1;
    tick();
    wr_en = 1'b0; clr_req = 1'b0;
    run_sweep(1'b0, 0, n);
    chk("sweep_len_simul", n, 8);
    rd_en = 1'b1; rd_addr = {3'd1, 3'd1}; tick();
    chk("reg1_after_simul", rd_data_a, 16'hA1A1);

    // Asynchronous reset in the middle of a sweep
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h77; tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = {3'd6, 3'd3}; tick();
    chk("pre_reset_read", rd_data_a, 16'h77A3);
    rd_en = 1'b0; clr_req = 1'b1; tick();
    clr_req = 1'b0; tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("midreset_busy", busy_a, 1'b0);
    chk("midreset_rd_data_a", rd_data_a, 16'h0);
    chk("midreset_rd_data_b", rd_data_b, 16'h0);
    chk("midreset_rd_valid", rd_valid_a, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = {3'(i), 3'(7 - i)};
      tick();
      chk("post_reset_init", rd_data_a, {8'(8'hA0 + i), 8'(8'hA7 - i)});
    end

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 8'($urandom_range(0, 255));
      rd_en   = ($urandom_range(0, 3) != 0);
      rd_addr = 6'($urandom_range(0, 63));
      clr_req = ($urandom_range(0, 39) == 0);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    n = 0;
    while (busy_a && n < 20) begin n++; tick(); end

    // Wide variant: 16x16, three read ports
    w_rd_en = 1'b1; w_rd_addr = {4'd7, 4'd0, 4'd15}; tick();
    chk("wide_reset_vals", w_rd_data, 48'h1007_1000_100F);
    chk("wide_rd_valid", w_rd_valid, 1'b1);
    w_rd_en = 1'b0;
    w_wr_en = 1'b1; w_wr_addr = 4'd15; w_wr_data = 16'hBEEF; tick();
    w_wr_addr = 4'd3; w_wr_data = 16'h1234; tick();
    w_wr_en = 1'b0; w_rd_en = 1'b1; w_rd_addr = {4'd9, 4'd3, 4'd15}; tick();
    chk("wide_three_port", w_rd_data, 48'h1009_1234_BEEF);
    w_rd_en = 1'b0; w_clr = 1'b1; tick();
    w_clr = 1'b0;
    n = 0;
    while (w_busy && n < 60) begin n++; tick(); end
    chk("wide_sweep_len", n, 16);
    w_rd_en = 1'b1; tick();
    chk("wide_after_sweep", w_rd_data, 48'h1009_1003_100F);
    w_rd_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
